// File: rtl/ppg_afe_model.sv
// ppg_afe_model: behavioural pulse-oximeter analog front end (LED driver, photodiode,
// DC-compensation DAC, PGA, 8-bit ADC) for closed-loop simulation and FPGA bring-up.
// Optional build macro PPG_AFE_NOISE_EN adds a small LFSR dither term to the raw sample;
// with the macro undefined the output is noise-free and bit-exact to the transfer formulas.
`timescale 1ns / 1ps

module ppg_afe_model #(
  parameter int unsigned BEAT_PERIOD = 1000,
  parameter int unsigned RISE_STEP   = 8,
  parameter int unsigned FALL_STEP   = 2,
  parameter int unsigned RED_DC      = 200,
  parameter int unsigned IR_DC       = 240,
  parameter int unsigned RED_AC      = 40,
  parameter int unsigned IR_AC       = 60,
  parameter int unsigned DC_STEP     = 4,
  parameter int unsigned DARK_LEVEL  = 16,
  parameter int unsigned SETTLE      = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [3:0] LED_DRIVE,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] ADC,
  output logic       ADC_Clip,
  output logic       Beat
);

  localparam int unsigned PhW  = (BEAT_PERIOD > 1) ? $clog2(BEAT_PERIOD) : 1;
  localparam int unsigned SetW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {StRise, StFall, StRest} pulse_e;
  typedef enum logic [1:0] {ChDark, ChRed, ChIr} chan_e;

  // ---------------------------------------------------------------------------
  // Heartbeat phase
  // ---------------------------------------------------------------------------
  logic [PhW-1:0] ph_q;
  logic           ph_wrap;
  logic           beat_q;

  assign ph_wrap = (ph_q == PhW'(BEAT_PERIOD - 1));

  // Phase counter wraps every BEAT_PERIOD cycles; Beat marks the cycle after the wrap.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      beat_q <= 1'b0;
    end else begin
      beat_q <= ph_wrap;
      ph_q   <= ph_wrap ? '0 : ph_q + PhW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse shape FSM
  // ---------------------------------------------------------------------------
  pulse_e     st_q, st_d;
  logic [7:0] p_q, p_d;
  int         p_up;
  int         p_dn;

  // Pulse state and amplitude register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      st_q <= StRise;
      p_q  <= '0;
    end else begin
      st_q <= st_d;
      p_q  <= p_d;
    end
  end

  // Saturating rise, saturating fall, rest at zero; phase wrap restarts the rise from p as-is.
  always_comb begin
    st_d = st_q;
    p_d  = p_q;
    p_up = int'(p_q) + int'(RISE_STEP);
    p_dn = int'(p_q) - int'(FALL_STEP);
    unique case (st_q)
      StRise: begin
        if (p_up >= 255) begin
          p_d  = 8'hFF;
          st_d = StFall;
        end else begin
          p_d = 8'(p_up);
        end
      end
      StFall: begin
        if (p_dn <= 0) begin
          p_d  = '0;
          st_d = StRest;
        end else begin
          p_d = 8'(p_dn);
        end
      end
      StRest: p_d = '0;
      default: begin
        st_d = StRise;
        p_d  = '0;
      end
    endcase
    if (ph_wrap) st_d = StRise;
  end

  // ---------------------------------------------------------------------------
  // Optional dither source
  // ---------------------------------------------------------------------------
`ifdef PPG_AFE_NOISE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Channel select and raw photodiode sample (stage 1 input)
  // ---------------------------------------------------------------------------
  chan_e              ch;
  int                 dc_term;
  int                 ac_term;
  int                 comp_term;
  int                 noise_term;
  int                 raw_int;
  logic signed [12:0] raw_d;

  // Exactly one LED lit selects that channel; anything else reads as dark.
  always_comb begin
    ch = ChDark;
    if (LED_RED && !LED_IR) ch = ChRed;
    else if (LED_IR && !LED_RED) ch = ChIr;
  end

  // Photodiode level scaled by drive, plus pulsatile part, minus DAC compensation.
  always_comb begin
    dc_term    = 0;
    ac_term    = 0;
    noise_term = 0;
    comp_term  = int'(DC_Comp) * int'(DC_STEP);
    unique case (ch)
      ChRed: begin
        dc_term = (int'(RED_DC) * int'(LED_DRIVE)) >>> 3;
        ac_term = (int'(RED_AC) * int'(p_q)) >>> 8;
      end
      ChIr: begin
        dc_term = (int'(IR_DC) * int'(LED_DRIVE)) >>> 3;
        ac_term = (int'(IR_AC) * int'(p_q)) >>> 8;
      end
      default: dc_term = int'(DARK_LEVEL);
    endcase
`ifdef PPG_AFE_NOISE_EN
    noise_term = int'(lfsr_q[2:0]) - 4;
`endif
    raw_int = dc_term + ac_term - comp_term + noise_term;
    raw_d   = 13'(raw_int);
  end

  // ---------------------------------------------------------------------------
  // Stage 1 register and settling tracker
  // ---------------------------------------------------------------------------
  logic signed [12:0] raw_q;
  chan_e              prev_ch;
  logic [3:0]         prev_drive;
  logic [6:0]         prev_comp;
  logic [3:0]         prev_gain;
  logic [SetW-1:0]    settle_q;
  logic               changed;

  assign changed = (ch != prev_ch) || (LED_DRIVE != prev_drive) ||
                   (DC_Comp != prev_comp) || (PGA_Gain != prev_gain);

  // prev_gain doubles as the stage-1 copy of the gain so stage 2 sees a matched pair.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      raw_q      <= '0;
      prev_ch    <= ChDark;
      prev_drive <= '0;
      prev_comp  <= '0;
      prev_gain  <= '0;
      settle_q   <= SetW'(SETTLE);
    end else begin
      raw_q      <= raw_d;
      prev_ch    <= ch;
      prev_drive <= LED_DRIVE;
      prev_comp  <= DC_Comp;
      prev_gain  <= PGA_Gain;
      if (changed) settle_q <= SetW'(SETTLE);
      else if (settle_q != '0) settle_q <= settle_q - SetW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: PGA about mid-scale, clamp to ADC range
  // ---------------------------------------------------------------------------
  logic signed [17:0] g;
  logic [7:0]         adc_d;
  logic               clip_d;
  logic [7:0]         adc_q;
  logic               clip_q;

  // Gain is applied around code 128; out-of-range results saturate and flag a clip.
  always_comb begin
    g      = 18'(128 + (int'(raw_q) - 128) * (int'(prev_gain) + 1));
    adc_d  = g[7:0];
    clip_d = 1'b0;
    if (g < 0) begin
      adc_d  = 8'h00;
      clip_d = 1'b1;
    end else if (g > 18'sd255) begin
      adc_d  = 8'hFF;
      clip_d = 1'b1;
    end
  end

  // ADC output holds while the front end is still settling.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      adc_q  <= '0;
      clip_q <= 1'b0;
    end else if (settle_q == '0) begin
      adc_q  <= adc_d;
      clip_q <= clip_d;
    end
  end

  assign ADC      = adc_q;
  assign ADC_Clip = clip_q;
  assign Beat     = beat_q;

endmodule
